uc_jogo_principal_param: RTL and testbench
==========================================

# uc_jogo_principal_param

Parametrised main-game control unit for the asteroids game. It sequences play capture, asteroid/shot movement and shot registration exactly as the fixed-lives controller did. It adds an internal lives counter, a level counter with extra-life reward, an idle timeout that forces movement when the player is inactive, a pause mode, a configurable save-wait length, and restart from game-over without reset. It sits at the top of the control hierarchy and drives the asteroid/shot coordinator and the shot registrar.

## Interface
- VIDAS_INICIAIS, 3: lives loaded at game start.
- VIDAS_MAX, 7: lives saturation ceiling; must fit in W_VIDAS.
- W_VIDAS, 3: width of the lives counter.
- W_NIVEL, 4: width of the level counter.
- ACERTOS_POR_NIVEL, 8: hits needed to advance one level; must be ≥1.
- TIMEOUT_CICLOS, 1000: idle cycles in espera_jogada before movement is forced; must be ≥2.
- CICLOS_SALVAMENTO, 2: cycles spent in espera_salvamento; must be ≥1.

Ports:
- clock in 1: single clock, rising edge.
- reset in 1: asynchronous, active-high.
- iniciar in 1: start or restart request.
- pausar in 1: single-cycle pause toggle pulse.
- ocorreu_jogada in 1: player input present.
- ocorreu_tiro in 1: registered play was a shot.
- colisao in 1: single-cycle pulse; ship hit, lose one life.
- acerto in 1: single-cycle pulse; asteroid destroyed.
- fim_movimentacao_asteroides_e_tiros in 1: coordinator done.
- fim_registra_tiros in 1: shot registrar done.
- enable_reg_jogada out 1
- reset_reg_jogada out 1
- inicia_registra_tiros out 1
- inicia_movimentacao_asteroides_e_tiros out 1
- reset_contadores out 1: clears the asteroid and shot counters.
- reset_maquinas out 1
- vidas out W_VIDAS
- nivel out W_NIVEL
- pausado out 1
- pronto out 1: game over.
- db_estado out 5

## Operation
- Moore FSM. State codes are also the db_estado values:
  - inicial 0
  - inicializa 1
  - espera_jogada 2
  - registra_jogada 3
  - termina_mov 4
  - espera_reg_tiros 5
  - fim_jogo 6
  - inicia_reg_tiros 7
  - espera_salvamento 8
  - pausa 9
  - erro F
- Transitions:
  - inicial: iniciar → inicializa.
  - inicializa → espera_jogada.
  - espera_jogada, checked in priority order:
    1. vidas==0 → fim_jogo.
    2. pausar → pausa.
    3. ocorreu_jogada → registra_jogada.
    4. Timeout counter == TIMEOUT_CICLOS-1 → termina_mov (forced move; no register).
    5. Otherwise stay.
  - registra_jogada → espera_salvamento.
  - espera_salvamento: hold CICLOS_SALVAMENTO cycles, then:
    - vidas==0 → fim_jogo.
    - else ocorreu_tiro → termina_mov.
    - else → espera_jogada.
  - termina_mov: on fim_movimentacao, vidas==0 → fim_jogo; otherwise → inicia_reg_tiros.
  - inicia_reg_tiros → espera_reg_tiros.
  - espera_reg_tiros: fim_registra_tiros → espera_jogada.
  - pausa: pausar → espera_jogada. colisao and acerto are ignored while paused.
  - fim_jogo: iniciar → inicializa.
  - erro or any unused code → inicial.
- Outputs:
  - reset_reg_jogada, reset_contadores and reset_maquinas are asserted in inicializa and fim_jogo.
  - enable_reg_jogada is asserted in registra_jogada.
  - inicia_registra_tiros is asserted in inicia_reg_tiros.
  - inicia_movimentacao_asteroides_e_tiros is asserted in espera_jogada.
  - pausado is asserted in pausa.
  - pronto is asserted in fim_jogo.
- Lives:
  - Loaded with VIDAS_INICIAIS in inicializa.
  - colisao decrements in every state except inicial, inicializa, pausa and fim_jogo.
  - Saturates at 0.
- Level:
  - The hit counter (width clog2(ACERTOS_POR_NIVEL+1)) and nivel are cleared in inicializa.
  - acerto is counted in the same states as colisao.
  - When the counter reaches ACERTOS_POR_NIVEL: clear it, increment nivel (saturating at all-ones), and add one life (saturating at VIDAS_MAX).
- Simultaneous colisao and level-up in the same cycle: net lives unchanged. The exception is vidas==VIDAS_MAX, where the result is VIDAS_MAX-1.
- Timeout counter:
  - Counts only in espera_jogada.
  - Cleared when leaving espera_jogada for any state other than pausa.
  - Held (not cleared) through pausa.

## Timing
- Reset values: state inicial; all single-bit outputs 0; vidas=0; nivel=0; db_estado=0; all internal counters 0.
- Lives and level update on the clock edge after the pulse. The FSM sees the new vidas one cycle later.
- Reset asserted mid-game: immediate return to inicial, all counters cleared, asynchronously.
- Forced move latency: exactly TIMEOUT_CICLOS cycles in espera_jogada, then termina_mov.
- Save-wait latency: registra_jogada to the next decision is 1+CICLOS_SALVAMENTO cycles.

## Structure
- Shared package uc_jogo_pkg holds the 5-bit state encodings (also used by the debug display decoder) and the db_estado width.
- One natural sub-module, contador_vidas_nivel: the lives, hit and level counters with saturation and the simultaneous-event rule. The FSM itself stays in the top block.

## Test plan
- Start game: reset, then iniciar → inicializa for one cycle with all three reset outputs high, then vidas=3, nivel=0, db_estado=2.
- Shot play with CICLOS_SALVAMENTO=2: ocorreu_jogada=1, ocorreu_tiro=1 → enable_reg_jogada for one cycle, 2 cycles in state 8, then state 4. fim_movimentacao → states 7 then 5. fim_registra_tiros → state 2.
- Idle: no input for TIMEOUT_CICLOS=10 cycles → state 4 on the 11th cycle. Pause at cycle 5 for 20 cycles, then resume → timeout fires 5 cycles after resume.
- Level-up: 8 acerto pulses → nivel=1 and vidas=4. At vidas=7, the 8th acerto together with colisao → vidas=6.
- Game over and restart: three colisao pulses → vidas=0 → fim_jogo with pronto=1. Further colisao leaves vidas at 0. iniciar → inicializa, vidas=3.
- Reset mid termina_mov → db_estado=0 and all outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/uc_jogo_pkg.sv
// uc_jogo_pkg: state encodings of the main game controller, shared with the debug display decoder
package uc_jogo_pkg;
  localparam int W_DB = 5;
  typedef enum logic [W_DB-1:0] {
    INICIAL           = 5'h0,
    INICIALIZA        = 5'h1,
    ESPERA_JOGADA     = 5'h2,
    REGISTRA_JOGADA   = 5'h3,
    TERMINA_MOV       = 5'h4,
    ESPERA_REG_TIROS  = 5'h5,
    FIM_JOGO          = 5'h6,
    INICIA_REG_TIROS  = 5'h7,
    ESPERA_SALVAMENTO = 5'h8,
    PAUSA             = 5'h9,
    ERRO              = 5'hF
  } estado_t;
endpackage

// File: rtl/contador_vidas_nivel.sv
// contador_vidas_nivel: lives, hit and level counters with saturation and the hit-and-level-up rule
module contador_vidas_nivel
  import uc_jogo_pkg::*;
#(
  parameter int VIDAS_INICIAIS    = 3,
  parameter int VIDAS_MAX         = 7,
  parameter int W_VIDAS           = 3,
  parameter int W_NIVEL           = 4,
  parameter int ACERTOS_POR_NIVEL = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               carregar,
  input  logic               conta,
  input  logic               colisao,
  input  logic               acerto,
  output logic [W_VIDAS-1:0] vidas,
  output logic [W_NIVEL-1:0] nivel
);
  localparam int W_AC = $clog2(ACERTOS_POR_NIVEL + 1);
  localparam logic [W_VIDAS-1:0] V_INI = W_VIDAS'(VIDAS_INICIAIS);
  localparam logic [W_VIDAS-1:0] V_MAX = W_VIDAS'(VIDAS_MAX);
  localparam logic [W_AC-1:0] AC_MAX = W_AC'(ACERTOS_POR_NIVEL);
  logic [W_VIDAS-1:0] vidas_q, vidas_d;
  logic [W_NIVEL-1:0] nivel_q, nivel_d;
  logic [W_AC-1:0] acertos_q, acertos_d, acertos_inc;
  logic sobe, perde;
  always_comb begin
    acertos_inc = acertos_q + W_AC'(acerto);
    sobe = conta && acertos_inc == AC_MAX;
    perde = conta && colisao;
    acertos_d = carregar ? '0 : !conta ? acertos_q : sobe ? '0 : acertos_inc;
    nivel_d = carregar ? '0 : (sobe && nivel_q != '1) ? nivel_q + W_NIVEL'(1) : nivel_q;
    // a hit on the level-up cycle cancels the bonus life, except at the ceiling where it still costs one
    vidas_d = carregar ? V_INI
      : (sobe && perde) ? (vidas_q == V_MAX ? V_MAX - W_VIDAS'(1) : vidas_q)
      : perde ? (vidas_q == '0 ? '0 : vidas_q - W_VIDAS'(1))
      : sobe ? (vidas_q >= V_MAX ? vidas_q : vidas_q + W_VIDAS'(1))
      : vidas_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vidas_q <= '0;
      nivel_q <= '0;
      acertos_q <= '0;
    end else begin
      vidas_q <= vidas_d;
      nivel_q <= nivel_d;
      acertos_q <= acertos_d;
    end
  end
  assign vidas = vidas_q;
  assign nivel = nivel_q;
endmodule

// File: rtl/uc_jogo_principal_param.sv
// uc_jogo_principal_param: main asteroids game controller with lives, levels, idle timeout and pause
module uc_jogo_principal_param
  import uc_jogo_pkg::*;
#(
  parameter int VIDAS_INICIAIS    = 3,
  parameter int VIDAS_MAX         = 7,
  parameter int W_VIDAS           = 3,
  parameter int W_NIVEL           = 4,
  parameter int ACERTOS_POR_NIVEL = 8,
  parameter int TIMEOUT_CICLOS    = 1000,
  parameter int CICLOS_SALVAMENTO = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               pausar,
  input  logic               ocorreu_jogada,
  input  logic               ocorreu_tiro,
  input  logic               colisao,
  input  logic               acerto,
  input  logic               fim_movimentacao_asteroides_e_tiros,
  input  logic               fim_registra_tiros,
  output logic               enable_reg_jogada,
  output logic               reset_reg_jogada,
  output logic               inicia_registra_tiros,
  output logic               inicia_movimentacao_asteroides_e_tiros,
  output logic               reset_contadores,
  output logic               reset_maquinas,
  output logic [W_VIDAS-1:0] vidas,
  output logic [W_NIVEL-1:0] nivel,
  output logic               pausado,
  output logic               pronto,
  output logic [W_DB-1:0]    db_estado
);
  localparam int W_TMO = $clog2(TIMEOUT_CICLOS);
  localparam int W_SV = $clog2(CICLOS_SALVAMENTO + 1);
  localparam logic [W_TMO-1:0] TMO_LIM = W_TMO'(TIMEOUT_CICLOS - 1);
  localparam logic [W_SV-1:0] SV_LIM = W_SV'(CICLOS_SALVAMENTO - 1);
  estado_t estado_q, estado_d;
  logic [W_TMO-1:0] tmo_q, tmo_d;
  logic [W_SV-1:0] sv_q, sv_d;
  logic sem_vidas, conta;
  contador_vidas_nivel #(
    .VIDAS_INICIAIS(VIDAS_INICIAIS), .VIDAS_MAX(VIDAS_MAX), .W_VIDAS(W_VIDAS),
    .W_NIVEL(W_NIVEL), .ACERTOS_POR_NIVEL(ACERTOS_POR_NIVEL)
  ) u_cnt (
    .clock(clock), .reset(reset), .carregar(estado_q == INICIALIZA), .conta(conta),
    .colisao(colisao), .acerto(acerto), .vidas(vidas), .nivel(nivel)
  );
  assign sem_vidas = vidas == '0;
  assign conta = !(estado_q inside {INICIAL, INICIALIZA, PAUSA, FIM_JOGO});
  always_comb begin
    estado_d = INICIAL;
    case (estado_q)
      INICIAL:           estado_d = iniciar ? INICIALIZA : INICIAL;
      INICIALIZA:        estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA:     estado_d = sem_vidas ? FIM_JOGO : pausar ? PAUSA
                                  : ocorreu_jogada ? REGISTRA_JOGADA
                                  : tmo_q == TMO_LIM ? TERMINA_MOV : ESPERA_JOGADA;
      REGISTRA_JOGADA:   estado_d = ESPERA_SALVAMENTO;
      ESPERA_SALVAMENTO: estado_d = sv_q != SV_LIM ? ESPERA_SALVAMENTO : sem_vidas ? FIM_JOGO
                                  : ocorreu_tiro ? TERMINA_MOV : ESPERA_JOGADA;
      TERMINA_MOV:       estado_d = !fim_movimentacao_asteroides_e_tiros ? TERMINA_MOV
                                  : sem_vidas ? FIM_JOGO : INICIA_REG_TIROS;
      INICIA_REG_TIROS:  estado_d = ESPERA_REG_TIROS;
      ESPERA_REG_TIROS:  estado_d = fim_registra_tiros ? ESPERA_JOGADA : ESPERA_REG_TIROS;
      PAUSA:             estado_d = pausar ? ESPERA_JOGADA : PAUSA;
      FIM_JOGO:          estado_d = iniciar ? INICIALIZA : FIM_JOGO;
      default:           estado_d = INICIAL;
    endcase
    // the idle count survives a pause so the forced move resumes where it left off
    tmo_d = estado_q != ESPERA_JOGADA ? tmo_q
          : !(estado_d inside {ESPERA_JOGADA, PAUSA}) ? '0
          : tmo_q == TMO_LIM ? tmo_q : tmo_q + W_TMO'(1);
    sv_d = (estado_q == ESPERA_SALVAMENTO && estado_d == ESPERA_SALVAMENTO) ? sv_q + W_SV'(1) : '0;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= INICIAL;
      tmo_q <= '0;
      sv_q <= '0;
    end else begin
      estado_q <= estado_d;
      tmo_q <= tmo_d;
      sv_q <= sv_d;
    end
  end
  assign enable_reg_jogada = estado_q == REGISTRA_JOGADA;
  assign reset_reg_jogada = estado_q inside {INICIALIZA, FIM_JOGO};
  assign reset_contadores = estado_q inside {INICIALIZA, FIM_JOGO};
  assign reset_maquinas = estado_q inside {INICIALIZA, FIM_JOGO};
  assign inicia_registra_tiros = estado_q == INICIA_REG_TIROS;
  assign inicia_movimentacao_asteroides_e_tiros = estado_q == ESPERA_JOGADA;
  assign pausado = estado_q == PAUSA;
  assign pronto = estado_q == FIM_JOGO;
  assign db_estado = estado_q;
endmodule

// File: tb/tb_uc_jogo_principal_param.sv
// tb_uc_jogo_principal_param: directed scenarios plus random play against a behavioural game model
module tb_uc_jogo_principal_param;
  localparam int T = 10, C = 2, VI = 3, VM = 7, AP = 8;
  localparam logic [7:0] INI = 8'h80, PAU = 8'h40, JOG = 8'h20, TIR = 8'h10;
  localparam logic [7:0] COL = 8'h08, ACE = 8'h04, FM = 8'h02, FR = 8'h01;
  logic clock = 0, reset = 1;
  logic iniciar = 0, pausar = 0, ocorreu_jogada = 0, ocorreu_tiro = 0;
  logic colisao = 0, acerto = 0, fim_mov = 0, fim_reg = 0;
  logic enable_reg_jogada, reset_reg_jogada, inicia_registra_tiros, inicia_mov;
  logic reset_contadores, reset_maquinas, pausado, pronto;
  logic [2:0] vidas;
  logic [3:0] nivel;
  logic [4:0] db_estado;
  int total = 0, bad = 0;
  int m_st, m_v, m_n, m_h, m_tmo, m_sv;
  always #5 clock = ~clock;
  uc_jogo_principal_param #(.TIMEOUT_CICLOS(T), .CICLOS_SALVAMENTO(C)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .pausar(pausar),
    .ocorreu_jogada(ocorreu_jogada), .ocorreu_tiro(ocorreu_tiro), .colisao(colisao),
    .acerto(acerto), .fim_movimentacao_asteroides_e_tiros(fim_mov),
    .fim_registra_tiros(fim_reg), .enable_reg_jogada(enable_reg_jogada),
    .reset_reg_jogada(reset_reg_jogada), .inicia_registra_tiros(inicia_registra_tiros),
    .inicia_movimentacao_asteroides_e_tiros(inicia_mov), .reset_contadores(reset_contadores),
    .reset_maquinas(reset_maquinas), .vidas(vidas), .nivel(nivel), .pausado(pausado),
    .pronto(pronto), .db_estado(db_estado)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask
  function automatic logic [7:0] exp_out(input int st);
    logic rst_out;
    rst_out = st == 1 || st == 6;
    return {st == 3, rst_out, st == 7, st == 2, rst_out, rst_out, st == 9, st == 6};
  endfunction
  function automatic logic [7:0] dut_out();
    return {enable_reg_jogada, reset_reg_jogada, inicia_registra_tiros, inicia_mov,
            reset_contadores, reset_maquinas, pausado, pronto};
  endfunction
  task automatic m_reset();
    m_st = 0; m_v = 0; m_n = 0; m_h = 0; m_tmo = 0; m_sv = 0;
  endtask
  task automatic check_all();
    chk("estado", db_estado, m_st);
    chk("vidas", vidas, m_v);
    chk("nivel", nivel, m_n);
    chk("saidas", dut_out(), exp_out(m_st));
  endtask
  task automatic step();
    int n;
    bit cnt, lvl;
    cnt = !(m_st inside {0, 1, 6, 9});
    case (m_st)
      0: n = iniciar ? 1 : 0;
      1: n = 2;
      2: n = m_v == 0 ? 6 : pausar ? 9 : ocorreu_jogada ? 3 : m_tmo >= T - 1 ? 4 : 2;
      3: n = 8;
      8: n = m_sv < C - 1 ? 8 : m_v == 0 ? 6 : ocorreu_tiro ? 4 : 2;
      4: n = !fim_mov ? 4 : m_v == 0 ? 6 : 7;
      7: n = 5;
      5: n = fim_reg ? 2 : 5;
      9: n = pausar ? 2 : 9;
      6: n = iniciar ? 1 : 6;
      default: n = 0;
    endcase
    if (m_st == 2) m_tmo = (n == 2 || n == 9) ? m_tmo + 1 : 0;
    m_sv = (m_st == 8 && n == 8) ? m_sv + 1 : 0;
    if (m_st == 1) begin
      m_v = VI; m_n = 0; m_h = 0;
    end else if (cnt) begin
      m_h += int'(acerto);
      lvl = m_h == AP;
      if (lvl) begin
        m_h = 0;
        if (m_n < 15) m_n++;
      end
      if (colisao && lvl) m_v = m_v == VM ? VM - 1 : m_v;
      else if (colisao) m_v = m_v > 0 ? m_v - 1 : 0;
      else if (lvl && m_v < VM) m_v++;
    end
    m_st = n;
  endtask
  task automatic cyc(input logic [7:0] in);
    check_all();
    {iniciar, pausar, ocorreu_jogada, ocorreu_tiro, colisao, acerto, fim_mov, fim_reg} = in;
    @(posedge clock);
    step();
    @(negedge clock);
  endtask
  initial begin
    logic [7:0] r;
    m_reset();
    repeat (2) @(negedge clock);
    check_all();
    reset = 0;
    cyc(INI);
    chk("inicializa_resets", {reset_reg_jogada, reset_contadores, reset_maquinas}, 3'b111);
    cyc(0);
    chk("inicio_vidas", vidas, 3);
    chk("inicio_estado", db_estado, 2);
    cyc(JOG | TIR);
    chk("enable_reg", enable_reg_jogada, 1);
    cyc(TIR);
    cyc(TIR);
    chk("salvamento", db_estado, 8);
    cyc(TIR);
    chk("tiro_mov", db_estado, 4);
    cyc(FM); cyc(0); cyc(FR);
    chk("volta_espera", db_estado, 2);
    repeat (T) cyc(0);
    chk("timeout", db_estado, 4);
    cyc(FM); cyc(0); cyc(FR);
    repeat (4) cyc(0);
    cyc(PAU);
    repeat (19) cyc(0);
    chk("pausado", pausado, 1);
    cyc(PAU);
    repeat (4) cyc(0);
    chk("pos_pausa", db_estado, 2);
    cyc(0);
    chk("timeout_pausa", db_estado, 4);
    cyc(FM); cyc(0); cyc(FR);
    repeat (AP) begin cyc(ACE); cyc(0); end
    chk("nivel_1", nivel, 1);
    chk("vidas_bonus", vidas, 4);
    repeat (3 * AP) begin cyc(ACE); cyc(0); end
    chk("vidas_max", vidas, 7);
    repeat (AP - 1) begin cyc(ACE); cyc(0); end
    cyc(ACE | COL);
    chk("teto_colisao", vidas, 6);
    repeat (6) begin cyc(COL); cyc(0); end
    cyc(FM); cyc(0);
    chk("fim_jogo", pronto, 1);
    cyc(COL); cyc(0);
    chk("sat_zero", vidas, 0);
    cyc(INI); cyc(0);
    chk("reinicio", vidas, 3);
    cyc(COL); cyc(0); cyc(COL); cyc(0); cyc(COL); cyc(0);
    chk("sem_vidas", db_estado, 6);
    cyc(INI); cyc(0);
    repeat (T) cyc(0);
    chk("mov_pre_reset", db_estado, 4);
    #2 reset = 1;
    #1;
    chk("rst_estado", db_estado, 0);
    chk("rst_saidas", dut_out(), 0);
    chk("rst_vidas", vidas, 0);
    m_reset();
    @(negedge clock);
    reset = 0;
    repeat (3000) begin
      r = {$urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
      cyc(r);
    end
    check_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
